// File: rtl/npc_pkg.sv
// Shared NPC core definitions.
// Holds the PC width, the canonical NOP encoding (addi x0, x0, 0) and the
// {pc, inst} record handed from fetch to decode.
package npc_pkg;

  localparam int XLEN = 64;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue.
// A DEPTH-entry circular buffer of {pc, inst} pairs.
// Fetch pushes under a valid/ready handshake. Decode pops the oldest entry.
// A flush discards every buffered entry when control flow is redirected.
//
// Ports:
//   clock, reset             single clock, asynchronous active-high reset
//   in_valid/in_pc/in_inst   fetch side entry
//   in_ready                 fetch side accept (fetch PC-advance enable)
//   out_valid/out_pc/
//   out_inst/out_misalign    head entry presented to decode
//   out_ready                decode consumes the head
//   flush                    discard all entries
module if_id_queue
  import npc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = npc_pkg::XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            in_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_misalign,
  input  logic            out_ready,
  input  logic            flush
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push;
  logic          pop;
  fetch_entry_t  head;

  // in_ready is derived only from the registered count. It never looks at
  // out_ready, so a full queue stays closed even when decode pops that cycle.
  assign in_ready  = (cnt_q < FullCnt) && !reset;
  assign out_valid = (cnt_q != '0);

  // Both handshakes are ignored while a flush is in progress.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // An empty queue shows PC 0 and a NOP, so a stray read in decode is harmless.
  assign head         = mem_q[rdPtr_q];
  assign out_pc       = out_valid ? head.pc : '0;
  assign out_inst     = out_valid ? head.inst : NOP_INST;
  assign out_misalign = out_valid && (out_pc[1:0] != 2'b00);

  // Pointer and count next-state logic. Pointers wrap naturally because
  // DEPTH is a power of two. Flush overrides every other update.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      cnt_d   = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + AW'(1);
      if (pop)  rdPtr_d = rdPtr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state register. It is cleared at once when reset asserts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      cnt_q   <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entry storage has no reset. The count alone decides which entries hold
  // live data.
  always_ff @(posedge clock) begin
    if (push) mem_q[wrPtr_q] <= '{pc: in_pc, inst: in_inst};
  end

endmodule
